// File: rtl/palette_fade_ram.sv
// Multi-bank writable 4:4:4 colour palette with a brightness fade engine.
// Index/bank in, scaled RGB out after a fixed 2-cycle pipeline.
module palette_fade_ram #(
  parameter int INDEX_W   = 4,
  parameter int COLOR_W   = 4,
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = 1,
  parameter int KEY_INDEX = 0,
  parameter int STEP_CYC  = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 pix_valid,
  input  logic [INDEX_W-1:0]   index,
  input  logic [BANK_W-1:0]    bank,
  input  logic                 wr_en,
  input  logic [BANK_W-1:0]    wr_bank,
  input  logic [INDEX_W-1:0]   wr_index,
  input  logic [3*COLOR_W-1:0] wr_rgb,
  input  logic                 fade_start,
  input  logic                 fade_dir,
  output logic                 fade_busy,
  output logic                 fade_done,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 rgb_valid
);

  // state  | meaning
  // IDLE   | level held, waiting for fade_start
  // FADING | level steps by 1 toward target every STEP_CYC cycles

  localparam int ENTRIES = 2**INDEX_W;
  localparam int RGB_W   = 3*COLOR_W;
  localparam int LVL_W   = COLOR_W+1;
  localparam int CNT_W   = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [LVL_W-1:0] LVL_FULL   = {1'b1, {COLOR_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STEP_CYC-1);

  typedef enum logic {IDLE, FADING} state_t;

  function automatic logic [RGB_W-1:0] default_entry(input int idx);
    logic [RGB_W-1:0] v;
    if (idx == 0)      v = {COLOR_W'(9), COLOR_W'(1), COLOR_W'(10)};
    else if (idx == 2) v = '0;
    else               v = {3{COLOR_W'(13)}};
    return v;
  endfunction

  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                               input logic [LVL_W-1:0] lvl);
    logic [COLOR_W+LVL_W-1:0] prod;
    prod = {{LVL_W{1'b0}}, c} * {{COLOR_W{1'b0}}, lvl};
    return COLOR_W'(prod >> COLOR_W);
  endfunction

  logic [RGB_W-1:0] pal [NUM_BANKS][ENTRIES];
  logic [RGB_W-1:0] rd_entry;

  // Each entry is its own register with a decoded write strobe; out-of-range banks match nothing.
  for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
    for (genvar ge = 0; ge < ENTRIES; ge++) begin : g_entry
      localparam logic [RGB_W-1:0] DEF = default_entry(ge);
      logic             wr_hit;
      logic [RGB_W-1:0] entry_q;

      assign wr_hit = wr_en && (wr_bank == BANK_W'(gb)) && (wr_index == INDEX_W'(ge));

      always_ff @(posedge Clk) begin
        if (Reset) begin
          entry_q <= DEF;
        end else if (wr_hit) begin
          entry_q <= wr_rgb;
        end
      end

      assign pal[gb][ge] = entry_q;
    end
  end

  always_comb begin
    rd_entry = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank == BANK_W'(b)) rd_entry = pal[b][index];
    end
  end

  logic [RGB_W-1:0] s1_rgb;
  logic             s1_key;
  logic             s1_valid;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_rgb   <= '0;
      s1_key   <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s1_rgb   <= rd_entry;
      s1_key   <= (index == INDEX_W'(KEY_INDEX));
      s1_valid <= pix_valid;
    end
  end

  logic [COLOR_W-1:0] s1_r, s1_g, s1_b;
  logic [LVL_W-1:0]   level;

  assign s1_r = s1_rgb[RGB_W-1 -: COLOR_W];
  assign s1_g = s1_rgb[2*COLOR_W-1 -: COLOR_W];
  assign s1_b = s1_rgb[COLOR_W-1:0];

  // The key colour bypasses scaling so the compositor can still match it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      rgb_valid <= 1'b0;
    end else begin
      red       <= s1_key ? s1_r : scale(s1_r, level);
      green     <= s1_key ? s1_g : scale(s1_g, level);
      blue      <= s1_key ? s1_b : scale(s1_b, level);
      rgb_valid <= s1_valid;
    end
  end

  state_t           state, state_nxt;
  logic [LVL_W-1:0] level_nxt, level_step, target;
  logic             dir_q, dir_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done_nxt;

  assign target    = dir_q ? LVL_FULL : '0;
  assign fade_busy = (state == FADING);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      level     <= LVL_FULL;
      dir_q     <= 1'b0;
      cnt       <= '0;
      fade_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      level     <= level_nxt;
      dir_q     <= dir_nxt;
      cnt       <= cnt_nxt;
      fade_done <= done_nxt;
    end
  end

  // A new start always wins: re-latch direction and restart the step timer from the current level.
  always_comb begin
    state_nxt  = state;
    level_nxt  = level;
    dir_nxt    = dir_q;
    cnt_nxt    = cnt;
    done_nxt   = 1'b0;
    level_step = dir_q ? (level + LVL_W'(1)) : (level - LVL_W'(1));
    if (fade_start) begin
      state_nxt = FADING;
      dir_nxt   = fade_dir;
      cnt_nxt   = CNT_RELOAD;
    end else if (state == FADING) begin
      if (level == target) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else if (cnt == '0) begin
        level_nxt = level_step;
        cnt_nxt   = CNT_RELOAD;
        if (level_step == target) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end
  end

endmodule
